// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the instruction-memory boot loader
//
// Purpose: loader FSM state encoding and the width of the length prefix.
// Ports: none (package).
package boot_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs accepted bytes little-endian into 32-bit words
//
// Purpose: collects three bytes in a shift register and presents the full
// word combinationally together with the fourth byte, so the caller can
// register the word on the same edge that accepts its last byte.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, clears partial word
//   accept_i     in   a byte is transferred on this edge
//   byte_i       in   byte value
//   word_o       out  {byte_i, b2, b1, b0}
//   word_valid_o out  accept_i on the 4th byte of a word
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] lo_q, lo_d;

    always_comb begin
        idx_d = idx_q;
        lo_d  = lo_q;
        if (accept_i) begin
            idx_d = idx_q + 2'd1;
            // Newest byte enters at the top so b0 ends up in bits [7:0].
            lo_d  = {byte_i, lo_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
            lo_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            lo_q  <= lo_d;
        end
    end

    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - length-prefixed byte stream to instruction memory loader
//
// Purpose: holds the core in reset, receives LEN_LO, LEN_HI and 4*N program
// bytes, writes each little-endian word to sequential instruction-memory
// addresses, then releases the core after RST_HOLD+1 further cycles.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   byte available
//   in_data    in   byte value
//   in_ready   out  loader accepts a byte (combinational, low during rst)
//   mem_we     out  one-cycle write strobe per word
//   mem_addr   out  word address
//   mem_wdata  out  instruction word
//   core_rst   out  core reset, active-high
//   done       out  program loaded, core running
//   err        out  declared length exceeds capacity
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [LEN_W:0] CAP = (LEN_W + 1)'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                accept;
    logic                pack_accept;
    logic                word_valid;
    logic [31:0]         word;
    logic [LEN_W-1:0]    len_full;

    assign accept      = in_valid && in_ready;
    assign pack_accept = accept && (state_q == S_DATA);
    assign len_full    = {in_data, len_lo_q};

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (pack_accept),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN0;
            len_lo_q    <= 8'd0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_full == '0) begin
                        state_d = S_HOLD;
                    end else if ({1'b0, len_full} > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        // Fits in ADDR_W+1 bits since it is at most 2^ADDR_W.
                        len_d   = len_full[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    word_cnt_d  = word_cnt_q + (ADDR_W + 1)'(1);
                    if (word_cnt_d == len_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Entered at edge E; leaves at edge E+RST_HOLD+1.
                if (hold_cnt_q == HOLD_W'(RST_HOLD)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN, S_ERR: begin
            end
            default: state_d = S_LEN0;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: in_ready = !rst;
            S_RUN: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: begin
            end
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_edge_q[$];
    int          acc[$];

    imem_boot_loader #(.ADDR_W(8), .RST_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_edge_q.push_back(edge_n);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            acc.push_back(edge_n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bs[$], input int gap);
        for (int i = 0; i < bs.size(); i++) begin
            send_byte(bs[i]);
            if (gap > 0 && i != bs.size() - 1) step(gap);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step(1);
        rst = 1'b0;
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_edge_q.delete();
        acc.delete();
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_wr_count"}, wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check({tag, "_addr0"}, {24'd0, wr_addr_q[0]}, 32'h0);
            check({tag, "_data0"}, wr_data_q[0], 32'h00000013);
            check({tag, "_edge0"}, wr_edge_q[0], acc[5]);
            check({tag, "_addr1"}, {24'd0, wr_addr_q[1]}, 32'h1);
            check({tag, "_data1"}, wr_data_q[1], 32'h00100093);
            check({tag, "_edge1"}, wr_edge_q[1], acc[9]);
        end
    endtask

    task automatic check_release(input string tag);
        // Called #1 after the final accept edge E.
        step(4);
        check({tag, "_core_rst_hold"}, {31'd0, core_rst}, 32'd1);
        check({tag, "_done_hold"}, {31'd0, done}, 32'd0);
        step(1);
        check({tag, "_core_rst_run"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_done_run"}, {31'd0, done}, 32'd1);
        check({tag, "_in_ready_run"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] big[$];
        int bad;

        prog = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step(2);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // N=2 at full rate
        send_seq(prog, 0);
        check("full_rate_span", acc[9] - acc[0], 9);
        check_release("full");
        check_two_words("full");

        // Same stream, 3 idle cycles between bytes
        do_reset();
        send_seq(prog, 3);
        check("gap_span", acc[9] - acc[0], 36);
        check_release("gap");
        check_two_words("gap");

        // N=0
        do_reset();
        send_seq('{8'h00, 8'h00}, 0);
        check_release("zero");
        check("zero_wr_count", wr_addr_q.size(), 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        step(3);
        check("zero_ignore_ready", {31'd0, in_ready}, 32'd0);
        check("zero_still_done", {31'd0, done}, 32'd1);
        in_valid = 1'b0;

        // Length 0x0101 exceeds 256 words
        do_reset();
        send_seq('{8'h01, 8'h01}, 0);
        check("err_set", {31'd0, err}, 32'd1);
        check("err_core_rst", {31'd0, core_rst}, 32'd1);
        check("err_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        step(3);
        check("err_sticky", {31'd0, err}, 32'd1);
        check("err_no_write", wr_addr_q.size(), 0);
        do_reset();
        check("err_cleared", {31'd0, err}, 32'd0);
        check("err_back_len0", {31'd0, in_ready}, 32'd1);

        // rst after two data bytes, then a fresh N=1 stream
        send_seq('{8'h01, 8'h00, 8'hAA, 8'hBB}, 0);
        rst = 1'b1;
        step(1);
        check("abort_core_rst", {31'd0, core_rst}, 32'd1);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_no_write", wr_addr_q.size(), 0);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_edge_q.delete();
        acc.delete();
        send_seq('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
        check_release("fresh");
        check("fresh_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("fresh_addr", {24'd0, wr_addr_q[0]}, 32'h0);
            check("fresh_data", wr_data_q[0], 32'h44332211);
        end

        // N=256: word k = {~k, C3, 5A, k}
        do_reset();
        big = '{8'h00, 8'h01};
        for (int k = 0; k < 256; k++) begin
            big.push_back(8'(k));
            big.push_back(8'h5A);
            big.push_back(8'hC3);
            big.push_back(~8'(k));
        end
        send_seq(big, 0);
        check("full_mem_err", {31'd0, err}, 32'd0);
        check_release("full_mem");
        check("full_mem_wr_count", wr_addr_q.size(), 256);
        if (wr_addr_q.size() == 256) begin
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                if (wr_addr_q[k] !== 8'(k)) bad++;
                if (wr_data_q[k] !== {~8'(k), 8'hC3, 8'h5A, 8'(k)}) bad++;
            end
            check("full_mem_seq_errs", bad, 0);
            check("full_mem_first_data", wr_data_q[0], 32'hFFC35A00);
            check("full_mem_last_addr", {24'd0, wr_addr_q[255]}, 32'hFF);
            check("full_mem_last_data", wr_data_q[255], 32'h00C35AFF);
        end
        check("full_mem_err_end", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
